// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between instruction fetch and data access, data first,
// with a sticky timeout error. Optional perf counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module memory_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        mem_err,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  // state  | meaning
  // IDLE   | no access in flight; data request wins over instruction
  // DATA   | data read/write on the RAM port
  // INSTR  | instruction fetch on the RAM port
  // DONE_D | dwait low for this single cycle
  // DONE_I | iwait low for this single cycle
  // ERROR  | access timed out; only RST leaves
  typedef enum logic [2:0] {IDLE, DATA, INSTR, DONE_D, DONE_I, ERROR} state_t;

  // cyc counts completed access cycles, so the last allowed one is TIMEOUT-1
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] cyc;
  logic             d_write;

  assign dwait = (state != DONE_D);
  assign iwait = (state != DONE_I);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      cyc      <= '0;
      d_write  <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      iload    <= '0;
      dload    <= '0;
      mem_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cyc <= '0;
          if (dREN | dWEN) begin
            state    <= DATA;
            d_write  <= dWEN;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
            ramaddr  <= daddr;
            ramstore <= dstore;
          end else if (iREN) begin
            state   <= INSTR;
            ramREN  <= 1'b1;
            ramWEN  <= 1'b0;
            ramaddr <= iaddr;
          end
        end
        DATA, INSTR: begin
          if (ram_ready) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (state == INSTR) begin
              iload <= ramload;
              state <= DONE_I;
            end else begin
              if (!d_write) dload <= ramload;
              state <= DONE_D;
            end
          end else if (cyc == LAST_CYC) begin
            ramREN  <= 1'b0;
            ramWEN  <= 1'b0;
            mem_err <= 1'b1;
            state   <= ERROR;
          end else begin
            cyc <= cyc + 1'b1;
          end
        end
        DONE_D, DONE_I: state <= IDLE;
        ERROR: begin
          ramREN  <= 1'b0;
          ramWEN  <= 1'b0;
          mem_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (state == DONE_I && icount != '1) icount <= icount + 32'd1;
      if (state == DONE_D && dcount != '1) dcount <= dcount + 32'd1;
    end
  end
`else
  assign icount = '0;
  assign dcount = '0;
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: a RAM responder model, a request driver and a
// monitor that checks each wait-low cycle against the expected completion queue.
module tb_memory_arbiter;
  localparam int TIMEOUT = 8;

`ifdef MEM_ARB_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [31:0] ramload;
  wire         ram_ready;
  logic        iwait, dwait, ramREN, ramWEN, mem_err;
  logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;

  logic resp_ready = 1'b0, mute = 1'b0, force_ready = 1'b0;
  int   fixed_delay = -1;
  assign ram_ready = mute ? force_ready : resp_ready;

  memory_arbiter #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramload(ramload), .ram_ready(ram_ready),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .mem_err(mem_err),
    .icount(icount), .dcount(dcount)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s: observed %h where no such event was allowed", name, act);
  endtask

  typedef struct { bit is_d; bit we; logic [31:0] addr; logic [31:0] store; logic [31:0] data; } exp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] store; } obs_t;
  exp_t exp_q[$];
  obs_t obs_q[$];

  // Reference memory contents (model) and the RAM's own storage (responder) kept separately
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] ram_mem   [logic [31:0]];
  logic [31:0] exp_dload = '0;
  int          n_i = 0, n_d = 0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  initial begin : responder
    bit   active;
    int   delay, cnt;
    obs_t cur;
    active = 0; delay = 0; cnt = 0;
    cur = '{we: 1'b0, addr: '0, store: '0};
    forever begin
      @(posedge CLK); #1;
      resp_ready = 1'b0;
      ramload    = $urandom;
      if (RST || !(ramREN || ramWEN)) begin
        active = 0;
      end else begin
        if (!active) begin
          active = 1; cnt = 0;
          delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
          cur.we = ramWEN; cur.addr = ramaddr; cur.store = ramstore;
          obs_q.push_back(cur);
        end
        check("ram_en_onehot", 32'(ramREN) + 32'(ramWEN), 32'd1);
        check("ram_addr_stable", ramaddr, cur.addr);
        if (cur.we) check("ram_store_stable", ramstore, cur.store);
        if (cnt == delay && !mute) begin
          resp_ready = 1'b1;
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          else ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_val(ramaddr);
          active = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    obs_t o;
    forever begin
      @(negedge CLK);
      if (!RST && (!dwait || !iwait)) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_done", {30'd0, dwait, iwait});
        end else begin
          e = exp_q.pop_front();
          check("done_side_waits", {30'd0, dwait, iwait}, e.is_d ? 32'd1 : 32'd2);
          if (e.is_d) check("dload", dload, e.data);
          else        check("iload", iload, e.data);
          if (obs_q.size() == 0) begin
            report_fail("ram_access_missing", e.addr);
          end else begin
            o = obs_q.pop_front();
            check("ram_we", 32'(o.we), 32'(e.we));
            check("ram_addr", o.addr, e.addr);
            if (e.we) check("ram_store", o.store, e.store);
          end
        end
      end
    end
  end

  int ren_cycles = 0, wen_cycles = 0;
  initial forever begin
    @(negedge CLK);
    if (ramREN) ren_cycles++;
    if (ramWEN) wen_cycles++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic reset_model();
    exp_dload = '0; n_i = 0; n_d = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic apply_reset();
    @(posedge CLK); #1;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    reset_model();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ramREN"}, 32'(ramREN), 32'd0);
    check({tag, "_ramWEN"}, 32'(ramWEN), 32'd0);
    check({tag, "_ramaddr"}, ramaddr, 32'd0);
    check({tag, "_ramstore"}, ramstore, 32'd0);
    check({tag, "_iload"}, iload, 32'd0);
    check({tag, "_dload"}, dload, 32'd0);
    check({tag, "_mem_err"}, 32'(mem_err), 32'd0);
    check({tag, "_waits"}, {30'd0, dwait, iwait}, 32'd3);
    check({tag, "_icount"}, icount, 32'd0);
    check({tag, "_dcount"}, dcount, 32'd0);
  endtask

  task automatic do_txn(input bit do_i, input bit do_d, input bit d_we,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] ds,
                        output int d_lat, output int i_lat);
    exp_t e;
    bit   dp, ip, d_drop, i_drop;
    int   cyc;
    d_lat = -1; i_lat = -1;
    if (do_d) begin
      e.is_d = 1; e.we = d_we; e.addr = da; e.store = ds;
      if (d_we) begin e.data = exp_dload; model_mem[da] = ds; end
      else begin e.data = model_rd(da); exp_dload = e.data; end
      exp_q.push_back(e);
      n_d++;
    end
    if (do_i) begin
      e.is_d = 0; e.we = 0; e.addr = ia; e.store = '0; e.data = model_rd(ia);
      exp_q.push_back(e);
      n_i++;
    end
    @(posedge CLK); #1;
    if (do_d) begin
      dREN = d_we ? 1'($urandom_range(0, 1)) : 1'b1;
      dWEN = d_we; daddr = da; dstore = ds;
    end
    if (do_i) begin iREN = 1'b1; iaddr = ia; end
    dp = do_d; ip = do_i; cyc = 0;
    while ((dp || ip) && cyc < 100) begin
      @(negedge CLK);
      cyc++;
      d_drop = 0; i_drop = 0;
      if (dp && !dwait) begin dp = 0; d_drop = 1; d_lat = cyc; end
      if (ip && !iwait) begin ip = 0; i_drop = 1; i_lat = cyc; end
      @(posedge CLK); #1;
      if (d_drop) begin dREN = 1'b0; dWEN = 1'b0; daddr = $urandom; dstore = $urandom; end
      if (i_drop) begin iREN = 1'b0; iaddr = $urandom; end
    end
    if (dp || ip) report_fail("txn_no_completion", 32'(cyc));
  endtask

  initial begin
    int dl, il, n_acc, cyc;
    bit hit;

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check_reset_state("reset");

    // Instruction fetch, ready on the first access cycle
    ram_mem[32'h40] = 32'h2001_000A;
    model_mem[32'h40] = 32'h2001_000A;
    fixed_delay = 0;
    ren_cycles = 0;
    do_txn(1, 0, 0, 32'h40, '0, '0, dl, il);
    check("t1_iwait_latency", 32'(il), 32'd3);
    check("t1_ren_cycles", 32'(ren_cycles), 32'd1);
    check("t1_iload", iload, 32'h2001_000A);

    // Simultaneous requests: data first, then instruction
    do_txn(1, 1, 0, 32'h44, 32'h80, '0, dl, il);
    check("t2_dwait_latency", 32'(dl), 32'd3);
    check("t2_iwait_latency", 32'(il), 32'd6);

    // Write held for four access cycles
    fixed_delay = 3;
    ren_cycles = 0; wen_cycles = 0;
    do_txn(0, 1, 1, '0, 32'h100, 32'hDEAD_BEEF, dl, il);
    check("t3_dwait_latency", 32'(dl), 32'd6);
    check("t3_wen_cycles", 32'(wen_cycles), 32'd4);
    check("t3_ren_cycles", 32'(ren_cycles), 32'd0);
    check("t3_dload_kept", dload, exp_dload);

    // Randomized traffic
    fixed_delay = -1;
    for (int k = 0; k < 150; k++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      do_txn(kind != 1, kind != 0, 1'($urandom_range(0, 1)), rnd_addr(), rnd_addr(), $urandom, dl, il);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
    end
    #1;
    check("rand_icount", icount, PERF ? 32'(n_i) : 32'd0);
    check("rand_dcount", dcount, PERF ? 32'(n_d) : 32'd0);
    check("rand_mem_err", 32'(mem_err), 32'd0);

    // Performance counters from a clean reset
    apply_reset();
    for (int k = 0; k < 3; k++) do_txn(1, 0, 0, rnd_addr(), '0, '0, dl, il);
    for (int k = 0; k < 2; k++) do_txn(0, 1, 0, '0, rnd_addr(), '0, dl, il);
    check("t6_icount", icount, PERF ? 32'd3 : 32'd0);
    check("t6_dcount", dcount, PERF ? 32'd2 : 32'd0);

    // Reset in the second cycle of an instruction access
    mute = 1'b1; force_ready = 1'b0;
    @(posedge CLK); #1;
    iREN = 1'b1; iaddr = 32'h44;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check("t5_in_access", 32'(ramREN), 32'd1);
    RST = 1'b1; iREN = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    reset_model();
    check("t5_ramREN", 32'(ramREN), 32'd0);
    check("t5_iload", iload, 32'd0);
    check("t5_iwait", 32'(iwait), 32'd1);
    force_ready = 1'b1;
    repeat (3) begin
      @(posedge CLK); #1;
      check("t5_late_ready_ren", 32'(ramREN), 32'd0);
      check("t5_late_ready_waits", {30'd0, dwait, iwait}, 32'd3);
      check("t5_late_ready_iload", iload, 32'd0);
    end
    force_ready = 1'b0;
    obs_q.delete();

    // Timeout with no ram_ready
    @(posedge CLK); #1;
    dREN = 1'b1; daddr = 32'h0C;
    n_acc = 0; cyc = 0; hit = 0;
    while (!hit && cyc < 50) begin
      @(negedge CLK);
      cyc++;
      if (mem_err) hit = 1;
      else if (ramREN) n_acc++;
    end
    if (!hit) report_fail("t4_no_error", 32'(cyc));
    check("t4_access_cycles", 32'(n_acc), 32'(TIMEOUT));
    check("t4_enables", {30'd0, ramREN, ramWEN}, 32'd0);
    check("t4_waits", {30'd0, dwait, iwait}, 32'd3);
    @(posedge CLK); #1;
    iREN = 1'b1; force_ready = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("t4_hold_err", 32'(mem_err), 32'd1);
      check("t4_hold_enables", {30'd0, ramREN, ramWEN}, 32'd0);
      check("t4_hold_waits", {30'd0, dwait, iwait}, 32'd3);
    end
    force_ready = 1'b0;
    apply_reset();
    mute = 1'b0;
    check_reset_state("t4_post");
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
